// File: rtl/ofifo_row_reader_pkg.sv
// ofifo_row_reader_pkg: default widths and pointer sizing shared by the output FIFO bank
package ofifo_row_reader_pkg;
  localparam int PSUM_BW = 16;
  localparam int NUM_COL = 8;
  localparam int OFIFO_DEPTH = 64;
  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction
endpackage

// File: rtl/ofifo_col_fifo.sv
// ofifo_col_fifo: one column FIFO with a registered pop output and an occupancy count
module ofifo_col_fifo import ofifo_row_reader_pkg::*; #(
  parameter int BW = PSUM_BW,
  parameter int DEPTH = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic [BW-1:0]          din,
  input  logic                   rd,
  output logic [BW-1:0]          dout,
  output logic [ptr_w(DEPTH):0]  count
);
  localparam int AW = ptr_w(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_wr;
  // a pop in the same cycle frees the slot a write into a full column needs
  assign do_wr = wr && (count != FULL || rd);
  always_ff @(posedge clk)
    if (do_wr) mem[wptr] <= din;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (rd) begin
        rptr <= rptr + 1'b1;
        dout <= mem[rptr];
      end
      count <= count + (AW+1)'(do_wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/ofifo_row_reader.sv
// ofifo_row_reader: per-column output FIFOs popped as whole rows under a valid/ready handshake.
// Define OFIFO_ERR_EN to add sticky o_overflow/o_underflow error flags.
module ofifo_row_reader import ofifo_row_reader_pkg::*; #(
  parameter int col = NUM_COL,
  parameter int bw = PSUM_BW,
  parameter int depth = OFIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [col-1:0]    wr,
  input  logic [col*bw-1:0] in,
  input  logic              rd,
  output logic [col*bw-1:0] out,
  output logic              o_full,
  output logic              o_ready,
`ifdef OFIFO_ERR_EN
  output logic              o_overflow,
  output logic              o_underflow,
`endif
  output logic              o_valid
);
  localparam int AW = ptr_w(depth);
  localparam logic [AW:0] FULL = (AW+1)'(depth);
  logic [AW:0] cnt [col];
  logic [col-1:0] full_v, nemp_v;
  logic pop;
  assign o_full  = |full_v;
  assign o_ready = !o_full;
  assign o_valid = &nemp_v;
  assign pop     = rd && o_valid;
`ifdef OFIFO_ERR_EN
  logic [col-1:0] drop_v;
`endif
  for (genvar i = 0; i < col; i++) begin : g_col
    ofifo_col_fifo #(.BW(bw), .DEPTH(depth)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[i]),
      .din   (in[i*bw +: bw]),
      .rd    (pop),
      .dout  (out[i*bw +: bw]),
      .count (cnt[i])
    );
    assign full_v[i] = cnt[i] == FULL;
    assign nemp_v[i] = cnt[i] != '0;
`ifdef OFIFO_ERR_EN
    assign drop_v[i] = wr[i] && full_v[i] && !pop;
`endif
  end
`ifdef OFIFO_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (|drop_v) o_overflow <= 1'b1;
      if (rd && !o_valid) o_underflow <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_ofifo_row_reader.sv
// tb_ofifo_row_reader: directed self-checking bench for the output FIFO bank
module tb_ofifo_row_reader;
  logic clk = 0, reset = 0, rd = 0;
  logic [7:0] wr = '0;
  logic [127:0] in_d = '0, out;
  logic o_full, o_ready, o_valid;
`ifdef OFIFO_ERR_EN
  logic o_overflow, o_underflow;
`endif
  int nvec = 0, nerr = 0;

  ofifo_row_reader dut (
    .clk(clk), .reset(reset), .wr(wr), .in(in_d), .rd(rd), .out(out),
    .o_full(o_full), .o_ready(o_ready),
`ifdef OFIFO_ERR_EN
    .o_overflow(o_overflow), .o_underflow(o_underflow),
`endif
    .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] row(input logic [15:0] base);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = base + 16'(i);
    return r;
  endfunction

  initial begin
    tick(); tick();
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_full", 128'(o_full), 128'(0));
    chk("rst_ready", 128'(o_ready), 128'(1));
    chk("rst_out", out, '0);
    reset = 1;
    tick();
    rd = 1;
    tick();
    rd = 0;
    chk("idle_rd_out", out, '0);
    chk("idle_rd_valid", 128'(o_valid), 128'(0));
    // full row in one cycle
    in_d = row(16'h0100); wr = 8'hFF;
    tick();
    wr = '0;
    chk("row_valid", 128'(o_valid), 128'(1));
    rd = 1;
    tick();
    rd = 0;
    chk("row_out", out, row(16'h0100));
    chk("row_valid_after", 128'(o_valid), 128'(0));
    // column 0 leads the rest by three cycles
    in_d = row(16'hA000); wr = 8'h01;
    tick();
    wr = '0;
    chk("skew_v0", 128'(o_valid), 128'(0));
    tick();
    chk("skew_v1", 128'(o_valid), 128'(0));
    tick();
    chk("skew_v2", 128'(o_valid), 128'(0));
    wr = 8'hFE;
    tick();
    wr = '0;
    chk("skew_v3", 128'(o_valid), 128'(1));
    rd = 1;
    tick();
    rd = 0;
    chk("skew_out", out, row(16'hA000));
    chk("skew_empty", 128'(o_valid), 128'(0));
    // fill column 3
    for (int k = 0; k < 64; k++) begin
      wr = 8'h08; in_d = '0; in_d[48 +: 16] = 16'h3000 + 16'(k);
      tick();
    end
    wr = '0;
    chk("fill_full", 128'(o_full), 128'(1));
    chk("fill_ready", 128'(o_ready), 128'(0));
    chk("fill_valid", 128'(o_valid), 128'(0));
    wr = 8'h08; in_d[48 +: 16] = 16'hDEAD;
    tick();
    wr = '0;
    chk("drop_full", 128'(o_full), 128'(1));
`ifdef OFIFO_ERR_EN
    chk("overflow", 128'(o_overflow), 128'(1));
    chk("underflow", 128'(o_underflow), 128'(1));
`endif
    wr = 8'hF7; in_d = row(16'h5000); in_d[48 +: 16] = 16'hDEAD;
    tick();
    chk("fill_pre_valid", 128'(o_valid), 128'(1));
    for (int k = 0; k < 64; k++) begin
      rd = 1;
      wr = (k < 63) ? 8'hF7 : 8'h00;
      in_d = '0;
      for (int i = 0; i < 8; i++) in_d[i*16 +: 16] = 16'h5000 + 16'(k + 1);
      tick();
      chk("drain_c3", 128'(out[48 +: 16]), 128'(16'h3000 + 16'(k)));
      chk("drain_c0", 128'(out[0 +: 16]), 128'(16'h5000 + 16'(k)));
      if (k == 0) chk("drain_full0", 128'(o_full), 128'(0));
    end
    rd = 0; wr = '0;
    chk("drain_valid", 128'(o_valid), 128'(0));
    chk("drain_full", 128'(o_full), 128'(0));
    // steady state: write and pop each cycle with one entry per column
    in_d = row(16'h0000); wr = 8'hFF;
    tick();
    for (int n = 0; n < 100; n++) begin
      in_d = row(16'((n + 1) * 8)); wr = 8'hFF; rd = 1;
      tick();
      chk("wrap_out", out, row(16'(n * 8)));
      chk("wrap_valid", 128'(o_valid), 128'(1));
      chk("wrap_full", 128'(o_full), 128'(0));
    end
    rd = 0;
    for (int n = 0; n < 4; n++) begin
      in_d = row(16'h9000 + 16'(n * 16)); wr = 8'hFF;
      tick();
    end
    wr = '0;
    chk("pre_rst_valid", 128'(o_valid), 128'(1));
    chk("pre_rst_out", out, row(16'(99 * 8)));
    // asynchronous reset between edges
    reset = 0;
    #1;
    chk("arst_valid", 128'(o_valid), 128'(0));
    chk("arst_out", out, '0);
    tick();
    reset = 1;
    rd = 1;
    tick();
    rd = 0;
    chk("post_rst_out", out, '0);
    chk("post_rst_valid", 128'(o_valid), 128'(0));
    in_d = row(16'hBEE0); wr = 8'hFF;
    tick();
    wr = '0; rd = 1;
    tick();
    rd = 0;
    chk("post_rst_row", out, row(16'hBEE0));
    chk("post_rst_empty", 128'(o_valid), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/ofifo_row_reader.md
Name: ofifo_row_reader

Overview:
- Output-side FIFO bank that collects per-column partial sums from the MAC array and hands them to the core controller as whole rows.
- Each column writes independently whenever its result is valid.
- The controller pops one complete row, all columns together, only when every column holds data.
- Counterpart of the input FIFO: there the array drains automatically; here an explicit reader drains under a valid/ready handshake.

Parameters:
- col, 8, number of MAC columns (independent column FIFOs)
- bw, 16, psum width per column in bits
- depth, 64, entries per column FIFO; must be a power of two, >= 2

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- wr  input  col  per-column write strobe; bit i writes in[i*bw +: bw]
- in  input  col*bw  per-column write data
- rd  input  1  row pop request from controller
- out  output  col*bw  registered popped row; column i at out[i*bw +: bw]
- o_full  output  1  at least one column FIFO is full
- o_ready  output  1  equals !o_full; array may issue writes
- o_valid  output  1  every column FIFO is non-empty; a row is available

Behaviour:
- Reset (reset==0, async) sets all pointers and counts to 0, out=0, o_full=0, o_ready=1, o_valid=0. Memory contents are don't-care.
- Reset asserted mid-operation discards all stored data immediately; the first rising edge after release behaves as post-reset.
- Per column: write pointer, read pointer, and count.
  - Pointer width is log2(depth); pointers wrap naturally from depth-1 to 0.
  - Count width is log2(depth)+1; count ranges 0..depth.
- Write: wr[i]==1 and count_i<depth stores in-data at wptr_i, then wptr_i+1 and count_i+1.
- Write to a full column (count_i==depth) is dropped with no state change.
- Pop: rd==1 and o_valid==1 at an edge:
  - every column stores mem[rptr_i] into its out slice;
  - each rptr_i increments and each count_i decrements.
- rd while o_valid==0 is ignored: out holds its value and no pointer moves.
- Simultaneous write and pop on the same column in one cycle: both take effect and count_i is unchanged. This is legal even when count_i==depth, because the pop frees a slot in the same cycle.
- Flags are combinational from registered counts:
  - o_full = OR over columns of (count_i==depth)
  - o_valid = AND over columns of (count_i!=0)
- Latency:
  - Data written at edge N raises o_valid after edge N, so it is poppable at edge N+1.
  - Popped data appears on out after the pop edge, giving 1-cycle read latency.
- No state machine. Columns are fully independent apart from the shared pop.
- Column skew up to depth-1 entries is tolerated.

Optional Feature:
- Macro: OFIFO_ERR_EN.
- With the macro defined, two extra output ports are added:
  - o_overflow (1 bit): set when any write is dropped.
  - o_underflow (1 bit): set when rd==1 while o_valid==0.
  - Both are sticky, cleared only by reset, and reset to 0.
- Without the macro, neither port exists. Dropped writes and ignored pops are silent, and all other behaviour is identical.

Decomposition:
- Shared package holds:
  - default widths: PSUM_BW=16, NUM_COL=8, OFIFO_DEPTH=64;
  - a function computing pointer width from depth.
- One natural sub-module: ofifo_col_fifo, a single-column depth x bw FIFO with wr, rd, dout, count outputs, instantiated col times by generate.
- The top level builds only o_valid, o_full and the shared pop.

Test Plan:
- Reset then idle: o_valid=0, o_full=0, o_ready=1, out=0. Asserting rd does not change out.
- Write row pattern in[i]=16'h0100+i to all 8 columns in one cycle, then rd:
  - o_valid=1 after the write edge;
  - out slice i = 16'h0100+i one cycle after the rd edge;
  - o_valid=0 afterwards.
- Skewed columns: column 0 written 3 cycles before columns 1-7. o_valid stays 0 until the last column write edge, then the popped row matches the written values.
- Fill column 3 with 64 writes:
  - o_full=1 and o_ready=0;
  - a 65th write with value 16'hDEAD is dropped (o_overflow=1 with OFIFO_ERR_EN);
  - 64 pops return the values in order, with no 16'hDEAD.
- Wrap-around: 100 interleaved write/pop cycles with all columns at count 1. Counts stay at 1, data stays in order across the pointer wrap, and o_full never asserts.
- Assert reset for 1 cycle with 5 rows stored: o_valid drops immediately and out=0. After release, rd is ignored until a new write.
